// File: rtl/fft_sample_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fft_sample_buffer                                          |
// | Description : Sample RAM and sequencer between the AXI bridge and the    |
// |               FFT engine. Natural-order real samples from the bridge are |
// |               stored as complex words at bit-reversed addresses, short   |
// |               loads are zero-padded, the engine is started and owns the  |
// |               RAM until done, then results are read back in natural      |
// |               order.                                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   i_clk, i_rst         clock, synchronous active-high reset              |
// |   i_LOG2N              FFT size exponent (clamped to 1..ADDR_WIDTH)      |
// |   i_WRITE_ram, i_SAMPLE_ram, i_SAMPLE_INDEX_ram  bridge sample writes    |
// |   i_DATA_LOADED        bridge end-of-load pulse (short loads get padded) |
// |   i_READ_ram, o_DATA_FROM_RAM  bridge result reads (1-cycle latency)     |
// |   o_CALC_END           results available (high throughout unload)        |
// |   o_SAMPLES_NUMBER     N-1                                               |
// |   o_START              one-cycle engine start pulse                      |
// |   i_ENG_ADDR, i_ENG_WE, i_ENG_WDATA, o_ENG_RDATA  engine RAM port        |
// |   i_ENG_DONE           engine finished pulse                             |
// |   o_OVERRUN            sticky error: misplaced write or out-of-range     |
// +--------------------------------------------------------------------------+
module fft_sample_buffer #(
    parameter int ADDR_WIDTH   = 12,
    parameter int SAMPLE_WIDTH = 16,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [3:0]              i_LOG2N,
    input  logic                    i_WRITE_ram,
    input  logic [SAMPLE_WIDTH-1:0] i_SAMPLE_ram,
    input  logic [ADDR_WIDTH-1:0]   i_SAMPLE_INDEX_ram,
    input  logic                    i_DATA_LOADED,
    input  logic                    i_READ_ram,
    output logic [DATA_WIDTH-1:0]   o_DATA_FROM_RAM,
    output logic                    o_CALC_END,
    output logic [ADDR_WIDTH-1:0]   o_SAMPLES_NUMBER,
    output logic                    o_START,
    input  logic [ADDR_WIDTH-1:0]   i_ENG_ADDR,
    input  logic                    i_ENG_WE,
    input  logic [DATA_WIDTH-1:0]   i_ENG_WDATA,
    output logic [DATA_WIDTH-1:0]   o_ENG_RDATA,
    input  logic                    i_ENG_DONE,
    output logic                    o_OVERRUN
);

    localparam logic [2:0] c_ST_LOAD   = 3'd0;
    localparam logic [2:0] c_ST_PAD    = 3'd1;
    localparam logic [2:0] c_ST_START  = 3'd2;
    localparam logic [2:0] c_ST_CALC   = 3'd3;
    localparam logic [2:0] c_ST_UNLOAD = 3'd4;

    localparam logic [3:0] c_LG_MAX = 4'(ADDR_WIDTH);

    // Reverse the low lg bits of a: reverse the whole word, then shift the
    // reversed field back down so the upper address bits come out zero.
    function automatic logic [ADDR_WIDTH-1:0] f_bitrev(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [3:0]            lg
    );
        logic [ADDR_WIDTH-1:0] v_r;
        for (int k = 0; k < ADDR_WIDTH; k++) begin
            v_r[k] = a[ADDR_WIDTH-1-k];
        end
        return v_r >> (c_LG_MAX - lg);
    endfunction

    logic [DATA_WIDTH-1:0]   r_mem [0:(2**ADDR_WIDTH)-1];

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [3:0]              r_lg;
    logic [3:0]              w_lg_clamp;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH:0]     w_count_nxt;
    logic [ADDR_WIDTH:0]     w_count_inc;
    logic [ADDR_WIDTH:0]     w_n;
    logic [ADDR_WIDTH:0]     w_n_m1;
    logic                    w_idx_ok;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic                    w_eng_rd;
    logic                    w_brg_rd;
    logic                    w_ovr_set;
    logic [DATA_WIDTH-1:0]   r_data_from_ram;
    logic [DATA_WIDTH-1:0]   r_eng_rdata;
    logic [ADDR_WIDTH-1:0]   r_samples_number;
    logic                    r_overrun;

    assign w_n         = (ADDR_WIDTH+1)'(1) << r_lg;
    assign w_n_m1      = w_n - 1'b1;
    assign w_count_inc = r_count + 1'b1;
    assign w_idx_ok    = {1'b0, i_SAMPLE_INDEX_ram} < w_n;

    always_comb begin
        w_lg_clamp = i_LOG2N;
        if (i_LOG2N == 4'd0) begin
            w_lg_clamp = 4'd1;
        end else if (i_LOG2N > c_LG_MAX) begin
            w_lg_clamp = c_LG_MAX;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_eng_rd    = 1'b0;
        w_brg_rd    = 1'b0;
        // Any bridge write outside LOAD is an error; LOAD refines this below.
        w_ovr_set   = i_WRITE_ram && (r_state != c_ST_LOAD);
        case (r_state)
            c_ST_LOAD: begin
                if (i_WRITE_ram) begin
                    if (w_idx_ok) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = f_bitrev(i_SAMPLE_INDEX_ram, r_lg);
                        w_mem_wdata = {i_SAMPLE_ram, {(DATA_WIDTH-SAMPLE_WIDTH){1'b0}}};
                        w_count_nxt = w_count_inc;
                    end else begin
                        w_ovr_set = 1'b1;
                    end
                end
                // A write completing the frame wins over a concurrent end-of-load.
                if (i_WRITE_ram && w_idx_ok && (w_count_inc == w_n)) begin
                    w_state_nxt = c_ST_START;
                end else if (i_DATA_LOADED) begin
                    w_state_nxt = c_ST_PAD;
                end
            end
            c_ST_PAD: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = f_bitrev(r_count[ADDR_WIDTH-1:0], r_lg);
                w_count_nxt = w_count_inc;
                if (w_count_inc == w_n) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                w_count_nxt = '0;
                w_state_nxt = c_ST_CALC;
            end
            c_ST_CALC: begin
                w_mem_we    = i_ENG_WE;
                w_mem_addr  = i_ENG_ADDR;
                w_mem_wdata = i_ENG_WDATA;
                w_eng_rd    = 1'b1;
                if (i_ENG_DONE) begin
                    w_state_nxt = c_ST_UNLOAD;
                end
            end
            c_ST_UNLOAD: begin
                w_mem_addr = i_SAMPLE_INDEX_ram;
                w_brg_rd   = i_READ_ram;
                if (i_READ_ram) begin
                    if (!w_idx_ok) begin
                        w_ovr_set = 1'b1;
                    end else if ({1'b0, i_SAMPLE_INDEX_ram} == w_n_m1) begin
                        w_state_nxt = c_ST_LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_LOAD;
            end
        endcase
    end

    // RAM array carries no reset; writes are suppressed while reset is held.
    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_rst) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= c_ST_LOAD;
            r_lg             <= 4'd1;
            r_count          <= '0;
            r_samples_number <= ADDR_WIDTH'(1);
            r_data_from_ram  <= '0;
            r_eng_rdata      <= '0;
            r_overrun        <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_count          <= w_count_nxt;
            r_samples_number <= w_n_m1[ADDR_WIDTH-1:0];
            // Size tracks i_LOG2N until the first sample of a frame lands.
            if ((r_state == c_ST_LOAD) && (r_count == '0)) begin
                r_lg <= w_lg_clamp;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            if (w_eng_rd) begin
                r_eng_rdata <= r_mem[w_mem_addr];
            end
            if (w_brg_rd) begin
                r_data_from_ram <= w_idx_ok ? r_mem[w_mem_addr] : '0;
            end
        end
    end

    assign o_DATA_FROM_RAM  = r_data_from_ram;
    assign o_ENG_RDATA      = r_eng_rdata;
    assign o_SAMPLES_NUMBER = r_samples_number;
    assign o_OVERRUN        = r_overrun;
    assign o_START          = (r_state == c_ST_START);
    assign o_CALC_END       = (r_state == c_ST_UNLOAD);

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fft_sample_buffer                                       |
// | Description : Self-checking bench for fft_sample_buffer. Frames of       |
// |               random size and content are loaded, processed by a fake    |
// |               engine and unloaded; results are compared against a        |
// |               bench-side memory image built from bit-reversal arithmetic.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fft_sample_buffer;

    localparam int AW = 12;
    localparam int SW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    log2n;
    logic          wr;
    logic [SW-1:0] sample;
    logic [AW-1:0] idx;
    logic          data_loaded;
    logic          rd;
    logic [DW-1:0] data_from_ram;
    logic          calc_end;
    logic [AW-1:0] samples_number;
    logic          start;
    logic [AW-1:0] eng_addr;
    logic          eng_we;
    logic [DW-1:0] eng_wdata;
    logic [DW-1:0] eng_rdata;
    logic          eng_done;
    logic          overrun;

    always #5 clk = ~clk;

    fft_sample_buffer #(.ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .DATA_WIDTH(DW)) u_dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_LOG2N            (log2n),
        .i_WRITE_ram        (wr),
        .i_SAMPLE_ram       (sample),
        .i_SAMPLE_INDEX_ram (idx),
        .i_DATA_LOADED      (data_loaded),
        .i_READ_ram         (rd),
        .o_DATA_FROM_RAM    (data_from_ram),
        .o_CALC_END         (calc_end),
        .o_SAMPLES_NUMBER   (samples_number),
        .o_START            (start),
        .i_ENG_ADDR         (eng_addr),
        .i_ENG_WE           (eng_we),
        .i_ENG_WDATA        (eng_wdata),
        .o_ENG_RDATA        (eng_rdata),
        .i_ENG_DONE         (eng_done),
        .o_OVERRUN          (overrun)
    );

    logic [DW-1:0] model [0:4095];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          exp_ovr  = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp_lg(input int v);
        if (v == 0) return 1;
        if (v > AW) return AW;
        return v;
    endfunction

    function automatic int brev(input int x, input int lg);
        int r = 0;
        for (int b = 0; b < lg; b++) r = r * 2 + ((x >> b) & 1);
        return r;
    endfunction

    // One complete frame: load k samples (padded to N), engine phase, unload.
    task automatic run_frame(input int lg_in, input int k, input bit errs);
        int            lg;
        int            n;
        int            bad_at;
        int            waited;
        int            a;
        int            nops;
        bit            dl_sent;
        logic [SW-1:0] s;
        logic [DW-1:0] d;
        logic [DW-1:0] last_eng;
        logic [DW-1:0] exp_data;
        lg      = clamp_lg(lg_in);
        n       = 1 << lg;
        dl_sent = 1'b0;
        log2n   = 4'(lg_in);
        tick;
        tick;
        chk_eq("samples_number", 32'(samples_number), 32'(n - 1));

        bad_at = (errs && k > 0) ? int'($urandom_range(0, k - 1)) : -1;
        for (int i = 0; i < k; i++) begin
            if ($urandom_range(0, 3) == 0) tick;
            if (i == bad_at) begin
                wr     = 1'b1;
                idx    = 12'(n + int'($urandom_range(0, 4095 - n)));
                sample = 16'($urandom);
                tick;
                wr      = 1'b0;
                exp_ovr = 1'b1;
            end
            s      = 16'($urandom);
            wr     = 1'b1;
            idx    = 12'(i);
            sample = s;
            model[brev(i, lg)] = {s, 16'h0000};
            if (i == k - 1 && $urandom_range(0, 1) == 1) begin
                data_loaded = 1'b1;
                dl_sent     = (k < n);
            end
            tick;
            wr          = 1'b0;
            data_loaded = 1'b0;
        end
        if (k < n && !dl_sent) begin
            repeat ($urandom_range(0, 2)) tick;
            data_loaded = 1'b1;
            tick;
            data_loaded = 1'b0;
        end
        for (int j = k; j < n; j++) model[brev(j, lg)] = '0;

        waited = 0;
        while (start !== 1'b1 && waited < 5000) begin
            tick;
            waited++;
        end
        chk_eq("start_latency", 32'(waited), 32'((k == n) ? 0 : n - k));
        chk_eq("start_high", 32'(start), 32'd1);
        tick;
        chk_eq("start_width", 32'(start), 32'd0);
        chk_eq("calc_end_in_calc", 32'(calc_end), 32'd0);

        nops = int'($urandom_range(4, 12));
        last_eng = '0;
        for (int op = 0; op < nops; op++) begin
            a = int'($urandom_range(0, n - 1));
            if (errs && op == 1) begin
                wr      = 1'b1;
                idx     = 12'($urandom_range(0, n - 1));
                sample  = 16'($urandom);
                exp_ovr = 1'b1;
            end
            if (op != nops - 1 && $urandom_range(0, 2) == 0) begin
                d         = $urandom;
                eng_we    = 1'b1;
                eng_addr  = 12'(a);
                eng_wdata = d;
                model[a]  = d;
                tick;
                eng_we    = 1'b0;
            end else begin
                eng_addr = 12'(a);
                tick;
                chk_eq("eng_rdata", eng_rdata, model[a]);
                last_eng = model[a];
            end
            wr = 1'b0;
        end
        eng_done = 1'b1;
        tick;
        eng_done = 1'b0;
        chk_eq("calc_end_rise", 32'(calc_end), 32'd1);

        exp_data = data_from_ram;
        for (int i = 0; i < n - 1; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                eng_we    = 1'b1;
                eng_addr  = 12'($urandom_range(0, n - 1));
                eng_wdata = $urandom;
                tick;
                eng_we = 1'b0;
                chk_eq("rd_hold", data_from_ram, exp_data);
                chk_eq("eng_hold", eng_rdata, last_eng);
            end
            rd  = 1'b1;
            idx = 12'(i);
            tick;
            rd = 1'b0;
            exp_data = model[i];
            chk_eq("unload_data", data_from_ram, exp_data);
            chk_eq("calc_end_hold", 32'(calc_end), 32'd1);
            if (errs && i == 0) begin
                rd  = 1'b1;
                idx = 12'(n + int'($urandom_range(0, 4095 - n)));
                tick;
                rd = 1'b0;
                exp_ovr  = 1'b1;
                exp_data = '0;
                chk_eq("bad_read_zero", data_from_ram, exp_data);
            end
        end
        rd  = 1'b1;
        idx = 12'(n - 1);
        tick;
        rd = 1'b0;
        chk_eq("unload_last", data_from_ram, model[n - 1]);
        chk_eq("calc_end_fall", 32'(calc_end), 32'd0);
        chk_eq("overrun", 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic chk_reset_outputs;
        chk_eq("rst_data", data_from_ram, 32'd0);
        chk_eq("rst_calc_end", 32'(calc_end), 32'd0);
        chk_eq("rst_samples_number", 32'(samples_number), 32'd1);
        chk_eq("rst_start", 32'(start), 32'd0);
        chk_eq("rst_eng_rdata", eng_rdata, 32'd0);
        chk_eq("rst_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        int st_hi;
        rst = 1'b1; log2n = 4'd3; wr = 1'b0; sample = '0; idx = '0;
        data_loaded = 1'b0; rd = 1'b0; eng_addr = '0; eng_we = 1'b0;
        eng_wdata = '0; eng_done = 1'b0;
        repeat (3) tick;
        chk_reset_outputs();
        rst = 1'b0;

        log2n = 4'd15; tick; tick;
        chk_eq("clamp_hi", 32'(samples_number), 32'd4095);
        log2n = 4'd0;  tick; tick;
        chk_eq("clamp_lo", 32'(samples_number), 32'd1);

        run_frame(3, 8, 1'b0);
        run_frame(3, 5, 1'b0);
        run_frame(2, 4, 1'b1);
        for (int it = 0; it < 16; it++) begin
            int lgi;
            int nn;
            lgi = int'($urandom_range(0, 6));
            nn  = 1 << clamp_lg(lgi);
            run_frame(lgi, int'($urandom_range(0, nn)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of padding.
        log2n = 4'd4; tick; tick;
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; idx = 12'(i); sample = 16'($urandom);
            tick;
        end
        wr = 1'b0; data_loaded = 1'b1;
        tick;
        data_loaded = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        chk_reset_outputs();
        rst = 1'b0;
        exp_ovr = 1'b0;
        st_hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (start === 1'b1) st_hi++;
        end
        chk_eq("no_start_after_rst", 32'(st_hi), 32'd0);

        run_frame(3, int'($urandom_range(0, 8)), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_sample_buffer.md
Name: fft_sample_buffer

Overview:
- Sample memory and sequencer between the AXI bridge RAM-side port and the FFT compute engine.
- Accepts natural-order 16-bit real samples from the bridge and stores each one as a 32-bit complex word at a bit-reversed address.
- Zero-pads short loads, starts the engine, then serves natural-order result reads back to the bridge.
- Owns the single-port result/sample RAM; arbitrates it between bridge and engine by state.

Parameters:
- ADDR_WIDTH, 12, RAM address width; max FFT size is 2^ADDR_WIDTH points.
- SAMPLE_WIDTH, 16, width of the real input sample.
- DATA_WIDTH, 32, RAM word width: {real[31:16], imag[15:0]}.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_LOG2N  in  4  FFT size exponent; N = 2^LOG2N.
- i_WRITE_ram  in  1  bridge sample write strobe.
- i_SAMPLE_ram  in  SAMPLE_WIDTH  bridge sample.
- i_SAMPLE_INDEX_ram  in  ADDR_WIDTH  bridge sample/result index, natural order.
- i_DATA_LOADED  in  1  bridge end-of-load pulse.
- i_READ_ram  in  1  bridge result read strobe.
- o_DATA_FROM_RAM  out  DATA_WIDTH  result word to bridge.
- o_CALC_END  out  1  results available.
- o_SAMPLES_NUMBER  out  ADDR_WIDTH  N-1.
- o_START  out  1  one-cycle engine start pulse.
- i_ENG_ADDR  in  ADDR_WIDTH  engine RAM address.
- i_ENG_WE  in  1  engine write enable.
- i_ENG_WDATA  in  DATA_WIDTH  engine write data.
- o_ENG_RDATA  out  DATA_WIDTH  engine read data.
- i_ENG_DONE  in  1  engine finished pulse.
- o_OVERRUN  out  1  sticky error flag.

Behaviour:
- States: LOAD, PAD, START, CALC, UNLOAD. Reset state is LOAD.
- Reset values: all outputs 0 except o_SAMPLES_NUMBER = 1. Internal lg register = 1, write count = 0.
- Reset is honoured mid-operation from any state. RAM contents are not cleared by reset.
- lg latching: in LOAD while count==0, lg <= clamp(i_LOG2N) every cycle. Clamp rules: 0 -> 1, >ADDR_WIDTH -> ADDR_WIDTH.
- o_SAMPLES_NUMBER is registered as (1<<lg)-1.
- LOAD, write accepted (i_WRITE_ram=1, index<N):
  - RAM[bitrev_lg(index)] <= {sample, 16'h0}.
  - count++.
  - bitrev_lg reverses the low lg bits; upper address bits are 0.
- LOAD, write with index>=N: dropped, o_OVERRUN <= 1, count unchanged.
- LOAD exit on count reaching N: when the accepted write makes count==N, go to START next cycle. A simultaneous i_DATA_LOADED is ignored.
- LOAD exit on i_DATA_LOADED with count<N:
  - Go to PAD.
  - PAD writes 0 to RAM[bitrev_lg(count)] and increments count, one word per cycle, until count==N, then goes to START.
  - A write in the same cycle as i_DATA_LOADED is accepted first.
- Writes outside LOAD: ignored, o_OVERRUN <= 1. Reads outside UNLOAD: ignored, o_DATA_FROM_RAM holds its value.
- START: o_START = 1 for exactly one cycle, count <= 0, then go to CALC.
- CALC:
  - RAM is owned by the engine.
  - Reads are registered: o_ENG_RDATA = RAM[i_ENG_ADDR] 1 cycle later.
  - i_ENG_WE writes i_ENG_WDATA.
  - Engine accesses in any other state are ignored and o_ENG_RDATA holds.
  - i_ENG_DONE moves to UNLOAD. o_CALC_END goes high on UNLOAD entry and stays high throughout UNLOAD.
- UNLOAD:
  - On i_READ_ram, o_DATA_FROM_RAM <= RAM[i_SAMPLE_INDEX_ram] (natural order, no reversal), 1-cycle latency.
  - A read of index N-1 returns its data, then the state goes to LOAD next cycle; o_CALC_END falls in that same cycle.
  - A read with index>=N sets o_OVERRUN and returns 0.
- i_ENG_DONE outside CALC: ignored.
- o_OVERRUN clears only on reset.

Test Plan:
- Full load: reset, LOG2N=3, write indices 0..7 with samples 0x0100+i -> RAM[4]=0x01010000, RAM[1]=0x01040000, RAM[7]=0x01070000; o_START pulses once the cycle after the 8th write; o_SAMPLES_NUMBER=7.
- Short load: LOG2N=3, write indices 0..4, then i_DATA_LOADED -> PAD lasts 3 cycles writing 0 to RAM[3], RAM[5], RAM[7]; o_START follows; o_OVERRUN=0.
- Engine phase: in CALC, engine writes 0xDEADBEEF to addr 2 and reads addr 2 the next cycle -> o_ENG_RDATA=0xDEADBEEF one cycle later; a concurrent bridge write sets o_OVERRUN=1 and leaves RAM unchanged.
- Unload: i_ENG_DONE, then bridge reads 0..7 -> each o_DATA_FROM_RAM matches RAM[i] one cycle after its strobe; o_CALC_END=1 until the cycle after the index-7 read; state returns to LOAD.
- Errors/clamp: LOG2N=15 -> o_SAMPLES_NUMBER=4095; with LOG2N=2, writing index 5 -> o_OVERRUN=1 and count unchanged.
- Reset mid-PAD: assert i_rst -> next cycle state LOAD, all outputs 0, o_SAMPLES_NUMBER=1, no o_START pulse.
